if_fetch_stage: RTL and testbench

- Instruction-fetch stage: PC register, instruction-memory request handshake, and the IF/ID pipeline register.
- Consumes the branch decision (br_taken, br_addr) produced by the EXE condition-check and address logic.
- Redirects the PC on a taken branch and flushes IF/ID.
- Honours the hazard unit's freeze using a one-entry skid buffer, so no fetched word is lost or duplicated.

---
 rtl/if_pkg.sv | 21 ++
 rtl/if_skid_buffer.sv | 30 +++
 rtl/if_fetch_stage.sv | 147 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage: FSM encoding, reset/step defaults
// and the IF/ID payload record.
package if_pkg;

   localparam int unsigned IF_ADDR_W   = 32;
   localparam int unsigned IF_INSTR_W  = 32;
   localparam logic [31:0] IF_RESET_PC = 32'h0;
   localparam int unsigned IF_PC_STEP  = 4;

   typedef enum logic [1:0] {
      REQ   = 2'b00,
      DROP  = 2'b01,
      STALL = 2'b10
   } if_state_t;

   typedef struct packed {
      logic [IF_ADDR_W-1:0]  pc;
      logic [IF_INSTR_W-1:0] instr;
   } if_payload_t;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry skid register: parks a fetched word while the pipeline is frozen.
// Clear has priority over load, load over unload.
module if_skid_buffer #(
   parameter type payload_t = if_pkg::if_payload_t
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     load,
   input  logic     unload,
   input  logic     clear,
   input  payload_t din,
   output payload_t dout,
   output logic     valid
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout  <= '0;
         valid <= 1'b0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         dout  <= din;
         valid <= 1'b1;
      end else if (unload) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, imem handshake, IF/ID register, branch redirect and
// freeze skid. Define IF_FETCH_PERF_EN to add fetch/flush performance counters.
module if_fetch_stage
   import if_pkg::*;
#(
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        INSTR_W  = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(IF_RESET_PC),
   parameter int unsigned        PC_STEP  = IF_PC_STEP
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               freeze,
   input  logic               br_taken,
   input  logic [ADDR_W-1:0]  br_addr,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_ready,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic               if_id_valid
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0]        perf_fetch_cnt,
   output logic [31:0]        perf_flush_cnt
`endif
);

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } payload_t;

   if_state_t         state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt, pc_inc;
   logic [ADDR_W-1:0] redir_addr, redir_nxt;
   payload_t          if_id, if_id_nxt, fetched, skid_data;
   logic              valid_nxt;
   logic              skid_load, skid_unload, skid_clear, skid_valid;

   assign pc_inc      = pc + ADDR_W'(PC_STEP);
   assign fetched     = '{pc: pc_inc, instr: imem_rdata};
   assign imem_req    = (state != STALL);
   assign imem_addr   = pc;
   assign if_id_pc    = if_id.pc;
   assign if_id_instr = if_id.instr;

   if_skid_buffer #(.payload_t(payload_t)) u_skid (
      .clk    (clk),
      .rst    (rst),
      .load   (skid_load),
      .unload (skid_unload),
      .clear  (skid_clear),
      .din    (fetched),
      .dout   (skid_data),
      .valid  (skid_valid)
   );

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      redir_nxt   = redir_addr;
      if_id_nxt   = if_id;
      valid_nxt   = if_id_valid;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_clear  = 1'b0;
      case (state)
         // The old request must still complete; only the redirect target may change.
         DROP: begin
            valid_nxt = 1'b0;
            if (br_taken) redir_nxt = br_addr;
            if (imem_ready) begin
               pc_nxt    = br_taken ? br_addr : redir_addr;
               state_nxt = REQ;
            end
         end
         STALL: begin
            if (br_taken) begin
               skid_clear = 1'b1;
               pc_nxt     = br_addr;
               valid_nxt  = 1'b0;
               state_nxt  = REQ;
            end else if (!freeze) begin
               if_id_nxt   = skid_data;
               valid_nxt   = skid_valid;
               skid_unload = 1'b1;
               state_nxt   = REQ;
            end
         end
         default: begin
            state_nxt = REQ;
            if (br_taken) begin
               valid_nxt = 1'b0;
               if (imem_ready) begin
                  pc_nxt = br_addr;
               end else begin
                  redir_nxt = br_addr;
                  state_nxt = DROP;
               end
            end else if (imem_ready) begin
               pc_nxt = pc_inc;
               if (freeze) begin
                  skid_load = 1'b1;
                  state_nxt = STALL;
               end else begin
                  if_id_nxt = fetched;
                  valid_nxt = 1'b1;
               end
            end else if (!freeze) begin
               valid_nxt = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= REQ;
         pc          <= RESET_PC;
         redir_addr  <= '0;
         if_id       <= '0;
         if_id_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         redir_addr  <= redir_nxt;
         if_id       <= if_id_nxt;
         if_id_valid <= valid_nxt;
      end
   end

`ifdef IF_FETCH_PERF_EN
   // Dropped words still count as fetches; flushes count every branch cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (imem_req && imem_ready) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (br_taken)               perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed scenarios then random traffic, checked
// against a behavioural fetch model. Honours IF_FETCH_PERF_EN for counter checks.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze, br_taken, imem_ready;
   logic [31:0] br_addr, imem_rdata;
   logic        imem_req, if_id_valid;
   logic [31:0] imem_addr, if_id_pc, if_id_instr;
`ifdef IF_FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   // Model state: fetch pointer, pending redirect, parked word, IF/ID contents.
   logic [31:0] m_pc, m_redir, m_ifpc, m_ifinstr;
   bit          m_ifvalid, m_dropping;
   logic [31:0] park_pc[$];
   logic [31:0] park_instr[$];
   logic [31:0] m_fetch_cnt, m_flush_cnt;

   if_fetch_stage dut (
      .clk         (clk),
      .rst         (rst),
      .freeze      (freeze),
      .br_taken    (br_taken),
      .br_addr     (br_addr),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ready  (imem_ready),
      .if_id_pc    (if_id_pc),
      .if_id_instr (if_id_instr),
      .if_id_valid (if_id_valid)
`ifdef IF_FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'hC0DE0000 ^ {a[15:0], a[31:16]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc        = 32'h0;
      m_redir     = 32'h0;
      m_ifpc      = 32'h0;
      m_ifinstr   = 32'h0;
      m_ifvalid   = 1'b0;
      m_dropping  = 1'b0;
      park_pc.delete();
      park_instr.delete();
      m_fetch_cnt = 32'h0;
      m_flush_cnt = 32'h0;
   endtask

   // One clock cycle: drive inputs, check handshake, clock, check IF/ID.
   task automatic step(input bit f, input bit b, input logic [31:0] ba, input bit r);
      bit          req, acc;
      logic [31:0] word;
      req        = (park_pc.size() == 0);
      acc        = r && req;
      word       = mem_word(m_pc);
      freeze     = f;
      br_taken   = b;
      br_addr    = ba;
      imem_ready = acc;
      imem_rdata = acc ? word : $urandom;
      #1;
      check("imem_req", {31'd0, imem_req}, {31'd0, req});
      if (req) check("imem_addr", imem_addr, m_pc);
      @(posedge clk);
      if (acc) m_fetch_cnt++;
      if (b) m_flush_cnt++;
      if (!req) begin
         if (b) begin
            park_pc.delete();
            park_instr.delete();
            m_pc      = ba;
            m_ifvalid = 1'b0;
         end else if (!f) begin
            m_ifpc    = park_pc.pop_front();
            m_ifinstr = park_instr.pop_front();
            m_ifvalid = 1'b1;
         end
      end else if (m_dropping) begin
         m_ifvalid = 1'b0;
         if (b) m_redir = ba;
         if (acc) begin
            m_pc       = m_redir;
            m_dropping = 1'b0;
         end
      end else if (b) begin
         m_ifvalid = 1'b0;
         if (acc) m_pc = ba;
         else begin
            m_redir    = ba;
            m_dropping = 1'b1;
         end
      end else if (acc) begin
         if (f) begin
            park_pc.push_back(m_pc + 32'd4);
            park_instr.push_back(word);
         end else begin
            m_ifpc    = m_pc + 32'd4;
            m_ifinstr = word;
            m_ifvalid = 1'b1;
         end
         m_pc = m_pc + 32'd4;
      end else if (!f) begin
         m_ifvalid = 1'b0;
      end
      #1;
      check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_ifvalid});
      if (m_ifvalid) begin
         check("if_id_pc", if_id_pc, m_ifpc);
         check("if_id_instr", if_id_instr, m_ifinstr);
      end
`ifdef IF_FETCH_PERF_EN
      check("perf_fetch_cnt", perf_fetch_cnt, m_fetch_cnt);
      check("perf_flush_cnt", perf_flush_cnt, m_flush_cnt);
`endif
   endtask

   task automatic check_reset_state();
      check("rst_imem_req", {31'd0, imem_req}, 32'd1);
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_if_id_valid", {31'd0, if_id_valid}, 32'd0);
      check("rst_if_id_pc", if_id_pc, 32'h0);
      check("rst_if_id_instr", if_id_instr, 32'h0);
`ifdef IF_FETCH_PERF_EN
      check("rst_perf_fetch", perf_fetch_cnt, 32'h0);
      check("rst_perf_flush", perf_flush_cnt, 32'h0);
`endif
   endtask

   initial begin
      rst        = 1'b1;
      freeze     = 1'b0;
      br_taken   = 1'b0;
      br_addr    = 32'h0;
      imem_ready = 1'b0;
      imem_rdata = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_state();
      rst = 1'b0;

      // Zero-wait stream
      step(0, 0, 32'h0, 1);
      step(0, 0, 32'h0, 1);
      step(0, 0, 32'h0, 1);
      check("zero_wait_pc", if_id_pc, 32'hC);

      // Freeze while a word returns, then release
      step(1, 0, 32'h0, 1);
      check("stall_req_low", {31'd0, imem_req}, 32'd0);
      step(1, 0, 32'h0, 0);
      step(1, 0, 32'h0, 0);
      step(0, 0, 32'h0, 0);
      check("unpark_pc", if_id_pc, 32'h10);
      check("unpark_instr", if_id_instr, mem_word(32'hC));

      // Taken branch with zero-wait memory
      step(0, 0, 32'h0, 1);
      step(0, 1, 32'h100, 1);
      check("br_flush_valid", {31'd0, if_id_valid}, 32'd0);
      step(0, 0, 32'h0, 1);
      check("br_target_pc", if_id_pc, 32'h104);

      // Branch during a memory wait, retargeted while dropping
      step(0, 0, 32'h0, 0);
      step(0, 1, 32'h40, 0);
      step(0, 0, 32'h0, 0);
      step(0, 1, 32'h80, 0);
      step(0, 0, 32'h0, 1);
      step(0, 0, 32'h0, 1);
      check("retarget_pc", if_id_pc, 32'h84);

      // Branch while stalled with a parked word
      step(1, 0, 32'h0, 1);
      step(1, 1, 32'h200, 0);
      step(0, 0, 32'h0, 1);
      check("stall_br_pc", if_id_pc, 32'h204);

      // Wrap at top of the address space
      step(0, 1, 32'hFFFFFFFC, 1);
      step(0, 0, 32'h0, 1);
      check("wrap_pc", if_id_pc, 32'h0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         bit          f, b, r;
         logic [31:0] ba;
         f  = ($urandom_range(0, 3) == 0);
         b  = ($urandom_range(0, 7) == 0);
         r  = ($urandom_range(0, 2) != 0);
         ba = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'h0000FFFC);
         step(f, b, ba, r);
      end

      // Asynchronous reset in the middle of a memory wait
      step(0, 0, 32'h0, 1);
      step(0, 0, 32'h0, 0);
      imem_ready = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      check_reset_state();
      model_reset();
      #2;
      rst = 1'b0;
      step(0, 0, 32'h0, 0);
      step(0, 0, 32'h0, 1);
      step(0, 0, 32'h0, 1);
      check("post_reset_pc", if_id_pc, 32'h8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
